output_stream_engine: RTL

Parametrised successor to the output stream manager. Drains the accumulation/output BRAM bank of the compute engine over an AXI4-Stream master (to DMA S2MM) after each batch completes. It adds:
- runtime-selectable bank count, length and traversal order;
- an optional batch header word;
- a configurable BRAM read latency;
- credit-based prefetch into a skid FIFO, so full throughput is held under arbitrary backpressure.

---
 rtl/output_stream_engine_pkg.sv | 20 ++
 rtl/output_stream_engine_skid_fifo.sv | 47 ++++
 rtl/output_stream_engine.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/output_stream_engine_pkg.sv
// Shared encodings for the output stream engine: traversal modes, FSM states
// and the batch header word layout.
package output_stream_engine_pkg;

   localparam logic MODE_INTERLEAVED = 1'b0;
   localparam logic MODE_SEQUENTIAL  = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HEADER = 3'd1,
      ST_STREAM = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   // Header word carries the zero-extended batch number in its low bits.
   localparam int HDR_BATCH_LSB = 0;
   localparam int HDR_BATCH_W   = 3;

endpackage

// File: rtl/output_stream_engine_skid_fifo.sv
// Synchronous show-ahead FIFO: head is valid whenever count is non-zero.
// Push on full is accepted only together with a pop; pop on empty is ignored.
module osm_skid_fifo #(
   parameter  int W     = 17,
   parameter  int DEPTH = 4,
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic [W-1:0]  push_dat_i,
   input  logic          pop_i,
   output logic [W-1:0]  head_dat_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push, do_pop;

   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   assign head_dat_o = mem_q[rd_ptr_q];
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;

endmodule

// File: rtl/output_stream_engine.sv
// Drains the output BRAM bank over AXI4-Stream after each batch, with optional header word.
// Reads are credit-limited against the skid FIFO so backpressure never drops or stalls a captured word.
module output_stream_engine
   import output_stream_engine_pkg::*;
#(
   parameter  int DW           = 16,
   parameter  int NUM_BRAMS    = 16,
   parameter  int ADDR_WIDTH   = 10,
   parameter  int OUTPUT_DEPTH = 512,
   parameter  int RD_LATENCY   = 1,
   parameter  int FIFO_DEPTH   = 4,
   localparam int NBW          = $clog2(NUM_BRAMS) + 1,
   localparam int LW           = $clog2(NUM_BRAMS),
   localparam int LENW         = ADDR_WIDTH + 1,
   localparam int WSW          = ADDR_WIDTH + $clog2(NUM_BRAMS) + 2,
   localparam int CW           = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic                             cfg_mode,
   input  logic [NBW-1:0]                   cfg_num_brams,
   input  logic [LENW-1:0]                  cfg_len,
   input  logic                             cfg_header_en,
   input  logic [2:0]                       batch_id,
   output logic                             ext_read_mode,
   output logic [NUM_BRAMS*ADDR_WIDTH-1:0]  ext_read_addr_flat,
   input  logic [NUM_BRAMS*DW-1:0]          bram_read_data_flat,
   output logic [DW-1:0]                    m_axis_tdata,
   output logic                             m_axis_tvalid,
   input  logic                             m_axis_tready,
   output logic                             m_axis_tlast,
   output logic                             busy,
   output logic                             done,
   output logic [WSW-1:0]                   words_sent,
   output logic                             err_start_busy
);

   state_e                state_q;
   logic                  mode_q, empty_frame_q, rd_active_q, err_q;
   logic [NBW-1:0]        nb_q;
   logic [LENW-1:0]       len_q;
   logic [2:0]            batch_q;
   logic [LW-1:0]         lane_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [RD_LATENCY-1:0] pipe_vld_q, pipe_last_q;
   logic [LW-1:0]         pipe_lane_q [RD_LATENCY];
   logic [WSW-1:0]        words_q;

   logic [NBW-1:0]        nb_clamp;
   logic [LENW-1:0]       len_clamp;
   logic                  zero_cfg, last_lane, last_addr, final_rd, issue, credit_ok;
   logic                  cap_vld, cap_last, hdr_push, fifo_push, fifo_empty, beat;
   logic [LW-1:0]         cap_lane;
   logic [DW-1:0]         cap_dat, hdr_dat;
   logic [DW:0]           fifo_push_dat, fifo_head;
   logic [CW-1:0]         fifo_count;
   int                    inflight;

   always_comb begin
      nb_clamp  = (cfg_num_brams > NBW'(NUM_BRAMS)) ? NBW'(NUM_BRAMS) : cfg_num_brams;
      len_clamp = (cfg_len > LENW'(OUTPUT_DEPTH)) ? LENW'(OUTPUT_DEPTH) : cfg_len;
      zero_cfg  = (nb_clamp == '0) || (len_clamp == '0);
      inflight  = 0;
      for (int i = 0; i < RD_LATENCY; i++) inflight += int'(pipe_vld_q[i]);
      // Counting in-flight reads as occupied guarantees every capture finds a free slot.
      credit_ok = (int'(fifo_count) + inflight) < FIFO_DEPTH;
      issue     = (state_q == ST_STREAM) && credit_ok;
      last_lane = ({1'b0, lane_q} == nb_q - NBW'(1));
      last_addr = ({1'b0, addr_q} == len_q - LENW'(1));
      final_rd  = last_lane && last_addr;
      cap_vld   = pipe_vld_q[RD_LATENCY-1];
      cap_last  = pipe_last_q[RD_LATENCY-1];
      cap_lane  = pipe_lane_q[RD_LATENCY-1];
      cap_dat   = bram_read_data_flat[int'(cap_lane)*DW +: DW];
      hdr_dat   = '0;
      hdr_dat[HDR_BATCH_LSB +: HDR_BATCH_W] = batch_q;
      hdr_push  = (state_q == ST_HEADER);
      fifo_push = hdr_push || cap_vld;
      fifo_push_dat = hdr_push ? {empty_frame_q, hdr_dat} : {cap_last, cap_dat};
   end

   osm_skid_fifo #(.W(DW + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (fifo_push),
      .push_dat_i (fifo_push_dat),
      .pop_i      (m_axis_tready),
      .head_dat_o (fifo_head),
      .empty_o    (fifo_empty),
      .count_o    (fifo_count)
   );

   assign beat = !fifo_empty && m_axis_tready;

   always_ff @(posedge clk) begin
      for (int i = RD_LATENCY - 1; i > 0; i--) pipe_lane_q[i] <= pipe_lane_q[i-1];
      pipe_lane_q[0] <= lane_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         mode_q        <= MODE_INTERLEAVED;
         empty_frame_q <= 1'b0;
         nb_q          <= '0;
         len_q         <= '0;
         batch_q       <= '0;
         lane_q        <= '0;
         addr_q        <= '0;
         pipe_vld_q    <= '0;
         pipe_last_q   <= '0;
         rd_active_q   <= 1'b0;
         err_q         <= 1'b0;
         words_q       <= '0;
      end else begin
         for (int i = RD_LATENCY - 1; i > 0; i--) begin
            pipe_vld_q[i]  <= pipe_vld_q[i-1];
            pipe_last_q[i] <= pipe_last_q[i-1];
         end
         pipe_vld_q[0]  <= issue;
         pipe_last_q[0] <= issue && final_rd;
         if (cap_vld && cap_last) rd_active_q <= 1'b0;
         if (beat) words_q <= words_q + WSW'(1);
         if (start && (state_q != ST_IDLE)) err_q <= 1'b1;
         case (state_q)
            ST_IDLE: if (start) begin
               mode_q        <= cfg_mode;
               nb_q          <= nb_clamp;
               len_q         <= len_clamp;
               batch_q       <= batch_id;
               empty_frame_q <= zero_cfg;
               lane_q        <= '0;
               addr_q        <= '0;
               words_q       <= '0;
               if (cfg_header_en) state_q <= ST_HEADER;
               else if (zero_cfg) state_q <= ST_DRAIN;
               else begin
                  state_q     <= ST_STREAM;
                  rd_active_q <= 1'b1;
               end
            end
            ST_HEADER: begin
               state_q     <= empty_frame_q ? ST_DRAIN : ST_STREAM;
               rd_active_q <= !empty_frame_q;
            end
            ST_STREAM: if (issue) begin
               if (mode_q == MODE_INTERLEAVED) begin
                  if (last_lane) begin
                     lane_q <= '0;
                     addr_q <= addr_q + ADDR_WIDTH'(1);
                  end else lane_q <= lane_q + LW'(1);
               end else begin
                  if (last_addr) begin
                     addr_q <= '0;
                     lane_q <= lane_q + LW'(1);
                  end else addr_q <= addr_q + ADDR_WIDTH'(1);
               end
               if (final_rd) begin
                  state_q <= ST_DRAIN;
                  lane_q  <= '0;
                  addr_q  <= '0;
               end
            end
            ST_DRAIN: if ((pipe_vld_q == '0) && fifo_empty) state_q <= ST_DONE;
            ST_DONE:  state_q <= ST_IDLE;
            default:  state_q <= ST_IDLE;
         endcase
      end
   end

   assign ext_read_mode      = rd_active_q;
   assign ext_read_addr_flat = {NUM_BRAMS{addr_q}};
   assign m_axis_tvalid      = !fifo_empty;
   assign m_axis_tdata       = fifo_empty ? '0 : fifo_head[DW-1:0];
   assign m_axis_tlast       = !fifo_empty && fifo_head[DW];
   assign busy               = (state_q != ST_IDLE);
   assign done               = (state_q == ST_DONE);
   assign words_sent         = words_q;
   assign err_start_busy     = err_q;

endmodule
